// File: rtl/pr_pkg.sv
// Shared types and constants for the pr_verilog_decoder transducer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pr_pkg;

    // Tracked transducer state; codes 101..111 are illegal and trigger a resync
    typedef enum logic [2:0] {
        ZT = 3'b000,
        ZD = 3'b001,
        ZU = 3'b010,
        ZO = 3'b011,
        ZP = 3'b100
    } state_t;

    // Two-bit symbols as seen on {t1,t2}
    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

    // Result of one table lookup: did the symbol match a row, which bit, where next
    typedef struct packed {
        logic   match;
        logic   x;
        state_t nxt;
    } lut_t;

    // True for the five defined state codes
    function automatic logic is_legal_state(input logic [2:0] s);
        return (s <= 3'b100);
    endfunction

endpackage

// File: rtl/pr_verilog_lut.sv
// Combinational transducer table: (state, symbol) -> {match, x, next_state}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle, the caller decides when to use it.
module pr_verilog_lut
    import pr_pkg::*;
(
    input  state_t     i_state,
    input  logic [1:0] i_sym,
    output lut_t       o_lut
);

    logic [1:0] w_row0_sym;
    logic [1:0] w_row1_sym;
    state_t     w_row0_nxt;
    state_t     w_row1_nxt;
    logic       w_legal;

    // Select the x=0 and x=1 rows of the current state
    always_comb begin
        w_row0_sym = SYM_00;
        w_row1_sym = SYM_00;
        w_row0_nxt = ZT;
        w_row1_nxt = ZT;
        w_legal    = 1'b1;
        case (i_state)
            ZT: begin
                w_row0_sym = SYM_01; w_row0_nxt = ZD;
                w_row1_sym = SYM_00; w_row1_nxt = ZO;
            end
            ZD: begin
                w_row0_sym = SYM_10; w_row0_nxt = ZU;
                w_row1_sym = SYM_11; w_row1_nxt = ZT;
            end
            ZU: begin
                w_row0_sym = SYM_00; w_row0_nxt = ZO;
                w_row1_sym = SYM_01; w_row1_nxt = ZD;
            end
            ZO: begin
                w_row0_sym = SYM_11; w_row0_nxt = ZT;
                w_row1_sym = SYM_10; w_row1_nxt = ZP;
            end
            ZP: begin
                w_row0_sym = SYM_00; w_row0_nxt = ZT;
                w_row1_sym = SYM_10; w_row1_nxt = ZU;
            end
            default: begin
                // Undefined state code: nothing matches
                w_legal = 1'b0;
            end
        endcase
    end

    // Compare the incoming symbol against both rows; the rows never share a symbol
    always_comb begin
        o_lut = '{match: 1'b0, x: 1'b0, nxt: ZT};
        if (w_legal && (i_sym == w_row0_sym)) begin
            o_lut = '{match: 1'b1, x: 1'b0, nxt: w_row0_nxt};
        end else if (w_legal && (i_sym == w_row1_sym)) begin
            o_lut = '{match: 1'b1, x: 1'b1, nxt: w_row1_nxt};
        end
    end

endmodule

// File: rtl/pr_verilog_decoder.sv
// Recovers the input bit stream of a 5-state transducer from its {t1,t2} symbols.
// Latency: 1 cycle from in_valid to x_out/x_valid; illegal symbols resync to ZT.
// Backpressure: none; a symbol is consumed on every cycle in_valid is high.
// Optional illegal-symbol counter enabled by defining PR_VERILOG_DECODER_ERRCNT_EN.
module pr_verilog_decoder
    import pr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    input  logic             t1,
    input  logic             t2,
    input  logic             clr_err,
    output logic             x_out,
    output logic             x_valid,
    output logic             err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] sym_cnt,
    output logic [7:0]       err_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_x_out;
    logic             r_x_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_sym_cnt;

    state_t           w_state_nxt;
    logic             w_x_nxt;
    logic             w_x_valid_nxt;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_sym_cnt_nxt;
    logic             w_err_evt;
    logic             w_bad_state;
    lut_t             w_lut;

    assign w_bad_state = !is_legal_state(r_state);

    pr_verilog_lut u_lut (
        .i_state (r_state),
        .i_sym   ({t1, t2}),
        .o_lut   (w_lut)
    );

    // Next-state and output decode; a corrupted state code takes priority over any symbol
    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x_out;
        w_x_valid_nxt = 1'b0;
        w_sym_cnt_nxt = r_sym_cnt;
        w_err_evt     = 1'b0;
        if (w_bad_state) begin
            w_state_nxt = ZT;
            w_err_evt   = 1'b1;
        end else if (in_valid) begin
            if (w_lut.match) begin
                w_state_nxt   = w_lut.nxt;
                w_x_nxt       = w_lut.x;
                w_x_valid_nxt = 1'b1;
                w_sym_cnt_nxt = r_sym_cnt + CNT_ONE;
            end else begin
                w_state_nxt = ZT;
                w_err_evt   = 1'b1;
            end
        end
        // Sticky error: a new error beats a simultaneous clear
        if (w_err_evt) begin
            w_err_nxt = 1'b1;
        end else if (clr_err) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            r_state   <= ZT;
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_err     <= 1'b0;
            r_sym_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_x_out   <= w_x_nxt;
            r_x_valid <= w_x_valid_nxt;
            r_err     <= w_err_nxt;
            r_sym_cnt <= w_sym_cnt_nxt;
        end
    end

`ifdef PR_VERILOG_DECODER_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Saturating illegal-symbol counter; counting beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!res) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_evt) begin
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end else if (clr_err) begin
            r_err_cnt <= 8'd0;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign x_out   = r_x_out;
    assign x_valid = r_x_valid;
    assign err     = r_err;
    assign state_o = r_state;
    assign sym_cnt = r_sym_cnt;

endmodule

// File: tb/tb_pr_verilog_decoder.sv
// Directed self-checking bench for pr_verilog_decoder.
// Latency: checks outputs 1 ns after the edge that consumed each symbol.
// Backpressure: n/a; every stimulus step is exactly one clock.
module tb_pr_verilog_decoder;

    logic       clk;
    logic       res;
    logic       in_valid;
    logic       t1;
    logic       t2;
    logic       clr_err;
    logic       x_out;
    logic       x_valid;
    logic       err;
    logic [2:0] state_o;
    logic [7:0] sym_cnt;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_bad = 0;

    pr_verilog_decoder #(.CNT_W(8)) dut (
        .clk      (clk),
        .res      (res),
        .in_valid (in_valid),
        .t1       (t1),
        .t2       (t2),
        .clr_err  (clr_err),
        .x_out    (x_out),
        .x_valid  (x_valid),
        .err      (err),
        .state_o  (state_o),
        .sym_cnt  (sym_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle past the rising edge
    task automatic step(input logic v, input logic [1:0] s, input logic clr, input logic rs);
        @(negedge clk);
        in_valid = v;
        t1       = s[1];
        t2       = s[0];
        clr_err  = clr;
        res      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        res      = 1'b0;
        in_valid = 1'b0;
        t1       = 1'b0;
        t2       = 1'b0;
        clr_err  = 1'b0;

        // Reset state
        do_reset();
        check("rst_state", state_o, 3'b000);
        check("rst_x", x_out, 1'b0);
        check("rst_xv", x_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cnt", sym_cnt, 8'd0);
        check("rst_errcnt", err_cnt, 8'd0);

        // 01,10,00 from ZT decodes 0,0,0 through ZD,ZU,ZO
        step(1'b1, 2'b01, 1'b0, 1'b1);
        check("a1_x", x_out, 1'b0); check("a1_xv", x_valid, 1'b1); check("a1_st", state_o, 3'b001);
        step(1'b1, 2'b10, 1'b0, 1'b1);
        check("a2_x", x_out, 1'b0); check("a2_xv", x_valid, 1'b1); check("a2_st", state_o, 3'b010);
        step(1'b1, 2'b00, 1'b0, 1'b1);
        check("a3_x", x_out, 1'b0); check("a3_xv", x_valid, 1'b1); check("a3_st", state_o, 3'b011);
        check("a3_cnt", sym_cnt, 8'd3);
        // Idle cycle holds everything and drops the strobe
        step(1'b0, 2'b10, 1'b0, 1'b1);
        check("idle_xv", x_valid, 1'b0); check("idle_st", state_o, 3'b011); check("idle_cnt", sym_cnt, 8'd3);

        // 00,10,10 from ZT decodes 1,1,1 through ZO,ZP,ZU
        do_reset();
        step(1'b1, 2'b00, 1'b0, 1'b1);
        check("b1_x", x_out, 1'b1); check("b1_xv", x_valid, 1'b1); check("b1_st", state_o, 3'b011);
        step(1'b1, 2'b10, 1'b0, 1'b1);
        check("b2_x", x_out, 1'b1); check("b2_xv", x_valid, 1'b1); check("b2_st", state_o, 3'b100);
        step(1'b1, 2'b10, 1'b0, 1'b1);
        check("b3_x", x_out, 1'b1); check("b3_xv", x_valid, 1'b1); check("b3_st", state_o, 3'b010);
        check("b3_cnt", sym_cnt, 8'd3);

        // Illegal symbol in ZT: err set, x_out held at 1, state stays ZT, count held
        do_reset();
        step(1'b1, 2'b01, 1'b0, 1'b1);   // ZT -> ZD, x=0
        step(1'b1, 2'b11, 1'b0, 1'b1);   // ZD -> ZT, x=1
        check("c0_x", x_out, 1'b1); check("c0_st", state_o, 3'b000);
        step(1'b1, 2'b10, 1'b0, 1'b1);   // illegal in ZT
        check("c1_err", err, 1'b1); check("c1_xv", x_valid, 1'b0); check("c1_st", state_o, 3'b000);
        check("c1_x", x_out, 1'b1); check("c1_cnt", sym_cnt, 8'd2);
        step(1'b1, 2'b01, 1'b0, 1'b1);   // resync: decodes x=0
        check("c2_x", x_out, 1'b0); check("c2_xv", x_valid, 1'b1); check("c2_st", state_o, 3'b001);
        check("c2_cnt", sym_cnt, 8'd3); check("c2_err", err, 1'b1);

        // Illegal symbol with clr_err in the same cycle: set wins; then clear alone
        step(1'b1, 2'b00, 1'b1, 1'b1);   // 00 illegal in ZD
        check("d1_err", err, 1'b1); check("d1_st", state_o, 3'b000); check("d1_xv", x_valid, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        check("d2_err", err, 1'b0);

        // Counter wrap: alternate 01 (ZT->ZD) and 11 (ZD->ZT), all legal
        do_reset();
        for (int i = 0; i < 255; i++) begin
            step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b11, 1'b0, 1'b1);
        end
        check("w255_cnt", sym_cnt, 8'd255); check("w255_st", state_o, 3'b001);
        step(1'b1, 2'b11, 1'b0, 1'b1);
        check("w256_cnt", sym_cnt, 8'd0); check("w256_st", state_o, 3'b000);
        check("w256_err", err, 1'b0);

        // Illegal-symbol counter: 300 illegal 10s in ZT
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'b10, 1'b0, 1'b1);
        end
`ifdef PR_VERILOG_DECODER_ERRCNT_EN
        check("ec_sat", err_cnt, 8'd255);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        check("ec_clr", err_cnt, 8'd0);
`else
        check("ec_off", err_cnt, 8'd0);
`endif
        check("ec_err", err, 1'b1 & ~clr_err);
        check("ec_cnt", sym_cnt, 8'd0);

        // Reset mid-sequence with a valid symbol present
        do_reset();
        step(1'b1, 2'b00, 1'b0, 1'b1);   // ZT -> ZO, x=1
        step(1'b1, 2'b10, 1'b0, 1'b1);   // illegal in ZO? no: 10 -> ZP, x=1
        step(1'b1, 2'b11, 1'b0, 1'b1);   // illegal in ZP -> err
        check("e0_err", err, 1'b1); check("e0_x", x_out, 1'b1);
        step(1'b1, 2'b01, 1'b0, 1'b0);   // reset wins over the valid 01
        check("e1_st", state_o, 3'b000); check("e1_x", x_out, 1'b0); check("e1_xv", x_valid, 1'b0);
        check("e1_err", err, 1'b0); check("e1_cnt", sym_cnt, 8'd0); check("e1_errcnt", err_cnt, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pr_verilog_decoder.md
PR_VERILOG_DECODER -- requirements
Module: pr_verilog_decoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of the decoded-symbol counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 res  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  high when {t1,t2} carries a symbol this cycle.
REQ-005 t1  input  1  symbol bit 1.
REQ-006 t2  input  1  symbol bit 0.
REQ-007 clr_err  input  1  clears the sticky error flag.
REQ-008 x_out  output  1  recovered input bit.
REQ-009 x_valid  output  1  one-cycle strobe: x_out holds a new bit.
REQ-010 err  output  1  sticky: an illegal symbol was received.
REQ-011 state_o  output  3  current tracked state code.
REQ-012 sym_cnt  output  CNT_W  count of successfully decoded symbols.
REQ-013 err_cnt  output  8  illegal-symbol counter (see Configuration).

Function
REQ-014 The block SHALL track a 5-state transducer: ZT=000, ZD=001, ZU=010, ZO=011, ZP=100; row format: state: x=0 -> next/{t1,t2}; x=1 -> next/{t1,t2}.
REQ-015 ZT: 0 -> ZD/01; 1 -> ZO/00.
REQ-016 ZD: 0 -> ZU/10; 1 -> ZT/11.
REQ-017 ZU: 0 -> ZO/00; 1 -> ZD/01.
REQ-018 ZO: 0 -> ZT/11; 1 -> ZP/10.
REQ-019 ZP: 0 -> ZT/00; 1 -> ZU/10.
REQ-020 On in_valid=1 with a symbol matching the x=0 (x=1) row of the current state, the block SHALL register x_out=0 (1), pulse x_valid=1, advance state, and increment sym_cnt; latency 1 cycle.
REQ-021 On in_valid=1 with a symbol matching neither row, the block SHALL set err=1, keep x_valid=0, hold x_out and sym_cnt, and force state to ZT (resync).
REQ-022 in_valid=0: x_valid=0; x_out, state, and sym_cnt hold.
REQ-023 sym_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 clr_err=1 clears err the next cycle, unless an illegal symbol arrives in the same cycle; set wins.
REQ-025 Illegal state codes 101/110/111 SHALL be forced to ZT on the next clock with err=1.

Reset
REQ-026 res=0 at a rising edge SHALL set state=ZT, x_out=0, x_valid=0, err=0, sym_cnt=0, err_cnt=0, overriding all other inputs, including mid-symbol.

Configuration
REQ-027 Macro PR_VERILOG_DECODER_ERRCNT_EN defined: err_cnt increments on each illegal symbol (REQ-021/025) and saturates at 255; clr_err also zeroes it.
REQ-028 Macro undefined: err_cnt SHALL be constant 0 and no counter logic is generated; the port list is unchanged.

Structure
REQ-029 Shared package pr_pkg SHALL hold the state typedef, the five state codes, and the 2-bit symbol constants.
REQ-030 Sub-module pr_verilog_lut (combinational): maps (state, symbol) to {match, x, next_state}; the decoder owns all registers.

Verification
REQ-031 Reset, then symbols 01,10,00 -> x_out 0,0,0 each with x_valid; state_o ZD,ZU,ZO; sym_cnt=3.
REQ-032 Reset, then symbols 00,10,10 -> x_out 1,1,1; state_o ZO,ZP,ZU; sym_cnt=3.
REQ-033 In ZT, symbol 10 -> err=1, x_valid=0, state_o=000, sym_cnt unchanged; next symbol 01 decodes x=0.
REQ-034 Illegal symbol with clr_err=1 in the same cycle -> err=1; clr_err alone next cycle -> err=0.
REQ-035 CNT_W=8, 256 valid symbols -> sym_cnt=0; with the macro defined, 300 illegal symbols -> err_cnt=255.
REQ-036 res=0 while in_valid=1 mid-sequence -> next cycle all outputs 0, state_o=000.
